// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded control unit: T-state counter, opcode/flag decode
//               into the 16-bit control word, flags register and halt latch.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int STEPS     = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic [15:0] ctrl,
    output logic [2:0]  t_step,
    output logic        flag_c,
    output logic        flag_z,
    output logic        halted
);

    localparam logic [2:0]  c_last_step = 3'(STEPS - 1);
    localparam logic [15:0] c_fetch_t0  = 16'h4004;
    localparam logic [15:0] c_fetch_t1  = 16'h1408;
    localparam logic [15:0] c_io_mi     = 16'h4800;
    localparam logic [15:0] c_ro_bi     = 16'h1020;
    localparam logic [15:0] c_io_j      = 16'h0802;
    localparam logic [15:0] c_hlt       = 16'h8000;

    logic [2:0]  r_t_step;
    logic        r_flag_c;
    logic        r_flag_z;
    logic        r_halted;
    logic [15:0] w_word;
    logic [15:0] w_next_word;
    logic [2:0]  w_next_step;

    // Microcode ROM; steps beyond T4 and unlisted opcodes decode to zero.
    function automatic logic [15:0] f_decode(
        input logic [2:0] step,
        input logic [3:0] op,
        input logic       fc,
        input logic       fz
    );
        logic [15:0] word;
        word = 16'h0000;
        case (step)
            3'd0: word = c_fetch_t0;
            3'd1: word = c_fetch_t1;
            3'd2: begin
                case (op)
                    4'b0001, 4'b0010, 4'b0011, 4'b0100: word = c_io_mi;
                    4'b0101: word = 16'h0A00;
                    4'b0110: word = c_io_j;
                    4'b0111: word = fc ? c_io_j : 16'h0000;
                    4'b1000: word = fz ? c_io_j : 16'h0000;
                    4'b1110: word = 16'h0110;
                    4'b1111: word = c_hlt;
                    default: word = 16'h0000;
                endcase
            end
            3'd3: begin
                case (op)
                    4'b0001:          word = 16'h1200;
                    4'b0010, 4'b0011: word = c_ro_bi;
                    4'b0100:          word = 16'h2100;
                    default:          word = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    4'b0010: word = 16'h0281;
                    4'b0011: word = 16'h02C1;
                    default: word = 16'h0000;
                endcase
            end
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    always_comb begin
        w_word      = f_decode(r_t_step, opcode, r_flag_c, r_flag_z);
        w_next_word = f_decode(r_t_step + 3'd1, opcode, r_flag_c, r_flag_z);
        w_next_step = r_t_step + 3'd1;
        if (r_t_step == c_last_step) begin
            w_next_step = 3'd0;
        end else if (EARLY_END && (r_t_step >= 3'd1) && (w_next_word == 16'h0000)) begin
            w_next_step = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_step <= 3'd0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_halted <= 1'b0;
        end else if (step_en && !r_halted) begin
            // Halt freezes the step counter where the HLT word was issued.
            if (w_word[15]) begin
                r_halted <= 1'b1;
            end else begin
                r_t_step <= w_next_step;
            end
            if (w_word[0]) begin
                r_flag_c <= alu_carry;
                r_flag_z <= alu_zero;
            end
        end
    end

    // Reset gates the word combinationally so no bus is driven mid-reset.
    assign ctrl   = !rst_n ? 16'h0000 : (r_halted ? c_hlt : w_word);
    assign t_step = r_t_step;
    assign flag_c = r_flag_c;
    assign flag_z = r_flag_z;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed vector bench for control_sequencer (early-end and
//               full-length instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_e = 1'b0;
    logic        rst_f = 1'b0;
    logic        se_e = 1'b0;
    logic        se_f = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        alu_carry = 1'b0;
    logic        alu_zero = 1'b0;
    logic [15:0] ctrl_e, ctrl_f;
    logic [2:0]  t_e, t_f;
    logic        fc_e, fz_e, h_e, fc_f, fz_f, h_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) u_dut_e (
        .clk(clk), .rst_n(rst_e), .step_en(se_e), .opcode(opcode),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .ctrl(ctrl_e),
        .t_step(t_e), .flag_c(fc_e), .flag_z(fz_e), .halted(h_e)
    );

    control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) u_dut_f (
        .clk(clk), .rst_n(rst_f), .step_en(se_f), .opcode(opcode),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .ctrl(ctrl_f),
        .t_step(t_f), .flag_c(fc_f), .flag_z(fz_f), .halted(h_f)
    );

    typedef struct {
        logic        se;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] ctrl;
        logic [2:0]  t;
        logic        fc;
        logic        fz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic se, input logic [3:0] op, input logic c, input logic z,
                       input logic [15:0] ct, input logic [2:0] t, input logic fc, input logic fz);
        vecs.push_back('{se, op, c, z, ct, t, fc, fz});
    endtask

    // Drive at the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic e, input logic f, input logic [3:0] op,
                         input logic c, input logic z);
        @(negedge clk);
        se_e = e; se_f = f; opcode = op; alu_carry = c; alu_zero = z;
        #1;
    endtask

    initial begin
        // Table for the early-end instance, starting from T0 with flags clear.
        add(1, 4'h1, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h1, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'h1, 0, 0, 16'h4800, 2, 0, 0);
        add(1, 4'h1, 0, 0, 16'h1200, 3, 0, 0);
        add(0, 4'h1, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h3, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h3, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'h3, 0, 0, 16'h4800, 2, 0, 0);
        add(1, 4'h3, 0, 0, 16'h1020, 3, 0, 0);
        add(1, 4'h3, 1, 1, 16'h02C1, 4, 0, 0);
        add(0, 4'h3, 0, 0, 16'h4004, 0, 1, 1);
        add(1, 4'h8, 0, 0, 16'h4004, 0, 1, 1);
        add(1, 4'h8, 0, 0, 16'h1408, 1, 1, 1);
        add(1, 4'h8, 0, 0, 16'h0802, 2, 1, 1);
        add(1, 4'h7, 0, 0, 16'h4004, 0, 1, 1);
        add(1, 4'h7, 0, 0, 16'h1408, 1, 1, 1);
        add(1, 4'h7, 0, 0, 16'h0802, 2, 1, 1);
        add(1, 4'h2, 0, 0, 16'h4004, 0, 1, 1);
        add(1, 4'h2, 0, 0, 16'h1408, 1, 1, 1);
        add(1, 4'h2, 0, 0, 16'h4800, 2, 1, 1);
        add(1, 4'h2, 0, 0, 16'h1020, 3, 1, 1);
        add(1, 4'h2, 0, 0, 16'h0281, 4, 1, 1);
        add(1, 4'h7, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h7, 0, 0, 16'h1408, 1, 0, 0);
        add(0, 4'h7, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h5, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h5, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'h5, 0, 0, 16'h0A00, 2, 0, 0);
        add(1, 4'hE, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'hE, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'hE, 0, 0, 16'h0110, 2, 0, 0);
        add(1, 4'h4, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h4, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'h4, 0, 0, 16'h4800, 2, 0, 0);
        add(1, 4'h4, 0, 0, 16'h2100, 3, 0, 0);
        add(1, 4'hA, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'hA, 0, 0, 16'h1408, 1, 0, 0);
        add(1, 4'h8, 0, 0, 16'h4004, 0, 0, 0);
        add(1, 4'h8, 0, 0, 16'h1408, 1, 0, 0);
        add(0, 4'h8, 0, 0, 16'h4004, 0, 0, 0);

        // Reset state and basic fetch.
        drive(0, 0, 4'h1, 0, 0);
        check("reset ctrl", ctrl_e, 16'h0000);
        check("reset t_step", 16'(t_e), 16'h0000);
        check("reset halted", 16'(h_e), 16'h0000);
        @(negedge clk); rst_e = 1'b1; #1;
        check("release ctrl", ctrl_e, 16'h4004);
        drive(1, 0, 4'h1, 0, 0);
        drive(0, 0, 4'h1, 0, 0);
        check("step1 t_step", 16'(t_e), 16'h0001);
        check("step1 ctrl", ctrl_e, 16'h1408);
        repeat (20) drive(0, 0, 4'h1, 0, 0);
        check("hold t_step", 16'(t_e), 16'h0001);
        check("hold ctrl", ctrl_e, 16'h1408);

        @(negedge clk); rst_e = 1'b0; #1;
        @(negedge clk); rst_e = 1'b1; #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].se, 0, vecs[i].op, vecs[i].c, vecs[i].z);
            check($sformatf("vec%0d ctrl", i), ctrl_e, vecs[i].ctrl);
            check($sformatf("vec%0d t_step", i), 16'(t_e), 16'(vecs[i].t));
            check($sformatf("vec%0d flag_c", i), 16'(fc_e), 16'(vecs[i].fc));
            check($sformatf("vec%0d flag_z", i), 16'(fz_e), 16'(vecs[i].fz));
        end

        // Full-length instance: LDA runs through an empty T4, then wraps.
        @(negedge clk); rst_f = 1'b1; #1;
        check("full T0", ctrl_f, 16'h4004);
        drive(0, 1, 4'h1, 0, 0);
        drive(0, 1, 4'h1, 0, 0);
        check("full T1", ctrl_f, 16'h1408);
        drive(0, 1, 4'h1, 0, 0);
        check("full T2", ctrl_f, 16'h4800);
        drive(0, 1, 4'h1, 0, 0);
        check("full T3", ctrl_f, 16'h1200);
        drive(0, 1, 4'h1, 0, 0);
        check("full T4 ctrl", ctrl_f, 16'h0000);
        check("full T4 t_step", 16'(t_f), 16'h0004);
        drive(0, 0, 4'h1, 0, 0);
        check("full wrap t_step", 16'(t_f), 16'h0000);
        // JC not taken with flag_c clear: empty T2 then T3.
        drive(0, 1, 4'h7, 0, 0);
        drive(0, 1, 4'h7, 0, 0);
        drive(0, 1, 4'h7, 0, 0);
        check("full JC T2 ctrl", ctrl_f, 16'h0000);
        check("full JC T2 t_step", 16'(t_f), 16'h0002);
        drive(0, 0, 4'h7, 0, 0);
        check("full JC T3 t_step", 16'(t_f), 16'h0003);

        // Halt latch on the early-end instance.
        drive(1, 0, 4'hF, 0, 0);
        drive(1, 0, 4'hF, 0, 0);
        drive(1, 0, 4'hF, 0, 0);
        check("HLT T2 ctrl", ctrl_e, 16'h8000);
        drive(0, 0, 4'hF, 0, 0);
        check("halted set", 16'(h_e), 16'h0001);
        repeat (10) drive(1, 0, 4'h3, 1, 1);
        check("halted t_step", 16'(t_e), 16'h0002);
        check("halted ctrl", ctrl_e, 16'h8000);
        check("halted flag_c", 16'(fc_e), 16'h0000);
        @(negedge clk); se_e = 1'b0; rst_e = 1'b0; #1;
        check("halt reset ctrl", ctrl_e, 16'h0000);
        check("halt reset halted", 16'(h_e), 16'h0000);
        @(negedge clk); rst_e = 1'b1; #1;

        // Async reset in the middle of ADD T3 with flag_c set.
        drive(1, 0, 4'h3, 0, 0);
        drive(1, 0, 4'h3, 0, 0);
        drive(1, 0, 4'h3, 0, 0);
        drive(1, 0, 4'h3, 0, 0);
        drive(1, 0, 4'h3, 1, 0);
        drive(1, 0, 4'h2, 0, 0);
        check("pre-ADD flag_c", 16'(fc_e), 16'h0001);
        drive(1, 0, 4'h2, 0, 0);
        drive(1, 0, 4'h2, 0, 0);
        drive(0, 0, 4'h2, 0, 0);
        check("ADD T3 ctrl", ctrl_e, 16'h1020);
        #2 rst_e = 1'b0;
        #1;
        check("async ctrl", ctrl_e, 16'h0000);
        check("async flag_c", 16'(fc_e), 16'h0000);
        check("async t_step", 16'(t_e), 16'h0000);
        @(negedge clk); rst_e = 1'b1; #1;
        check("async release ctrl", ctrl_e, 16'h4004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
